btn_event_unit: RTL
===================

# btn_event_unit

Parametrised multi-channel push-button conditioner for the debug/game top level. It replaces per-button debounce instances and ad-hoc edge/press counters with one block. Each channel provides a synchronised, debounced level, one-cycle rise and fall pulses, and a wrapping press counter. It also provides long-press (hold) detection and optional auto-repeat pulses. Outputs feed the character controller and the sequence-debug display.

## Interface
- BTN_NUM, 3, number of independent button channels (≥1)
- CNT_WIDTH, 16, press-counter width per channel
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a level change (≥2)
- HOLD_CYCLES, 50000000, cycles of accepted press before hold asserts (≥2)
- REPEAT_CYCLES, 10000000, auto-repeat period once held (≥2)

Ports:
- sys_clk  in  1  system clock, single clock domain
- sys_rst_n  in  1  asynchronous active-low reset
- btn_raw  in  BTN_NUM  raw, asynchronous, bouncing button inputs
- cnt_clr  in  BTN_NUM  per-channel synchronous press-counter clear
- btn_level  out  BTN_NUM  debounced level
- btn_rise  out  BTN_NUM  one-cycle pulse on accepted press
- btn_fall  out  BTN_NUM  one-cycle pulse on accepted release
- btn_hold  out  BTN_NUM  high while pressed ≥ HOLD_CYCLES
- btn_rpt  out  BTN_NUM  auto-repeat pulses (see Configuration)
- btn_cnt  out  BTN_NUM*CNT_WIDTH  press counters; channel i at [i*CNT_WIDTH +: CNT_WIDTH]

## Operation
- All outputs are registered. Reset value of every output and every internal register is 0.
- Synchroniser: 2-flop chain per channel. The output is `sync`.
- Debounce counter `db_cnt` (width $clog2(DEBOUNCE_CYCLES)):
  - Increments each cycle that sync ≠ btn_level.
  - Clears to 0 on any cycle that sync = btn_level, so a glitch restarts qualification.
  - When db_cnt = DEBOUNCE_CYCLES−1 and sync ≠ btn_level, btn_level toggles and db_cnt clears.
- Edge pulses: on the toggle to 1, btn_rise = 1 for exactly one cycle, aligned with the btn_level change. On the toggle to 0, btn_fall behaves the same way.
- Press counter: increments by 1 on each btn_rise and wraps modulo 2^CNT_WIDTH.
  - cnt_clr forces 0 on the next edge.
  - cnt_clr has priority over a simultaneous rise, so the result is 0, not 1.
- Per-channel FSM:
  - IDLE: btn_level = 0. A rise moves the FSM to PRESS and loads hold_cnt = 0.
  - PRESS: hold_cnt increments each cycle.
    - When hold_cnt = HOLD_CYCLES−1, go to HELD; btn_hold rises on that edge.
    - A fall returns the FSM to IDLE.
  - HELD: btn_hold = 1. Repeat logic runs (if compiled in). A fall returns to IDLE with btn_hold = 0 on the same edge as btn_fall.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.

## Timing
- Raw press, stable, first seen at edge T: sync is valid at T+2 and btn_level/btn_rise at T+2+DEBOUNCE_CYCLES. Release latency is the same.
- btn_cnt shows the incremented value on the same cycle btn_rise is high.
- btn_hold asserts HOLD_CYCLES cycles after btn_rise.
- Bounce shorter than DEBOUNCE_CYCLES produces no level change, no pulses and no count.
- Reset asserted mid-debounce or mid-hold clears everything asynchronously. A button still held after reset deasserts is treated as a new press: rise after 2+DEBOUNCE_CYCLES, count 1.
- Counter wrap: cnt = 2^CNT_WIDTH−1 plus a rise gives 0. No flag is raised.

## Configuration
- BTN_AUTO_REPEAT_EN defined:
  - In HELD, a per-channel rpt_cnt (width $clog2(REPEAT_CYCLES)) runs.
  - btn_rpt pulses for one cycle on the HELD-entry edge, then every REPEAT_CYCLES cycles while held.
  - Leaving HELD clears rpt_cnt immediately, with no pulse on the fall cycle.
- Not defined: btn_rpt is tied to 0, rpt_cnt is not instantiated, and hold behaviour is unchanged.

## Test plan
Parameters for all scenarios: BTN_NUM=3, CNT_WIDTH=4, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3.

1. Reset → all outputs 0. Press ch0 clean → btn_level[0]/btn_rise[0] at T+6, rise high 1 cycle, btn_cnt[3:0]=1.
2. Bounce: ch1 toggles high 3 cycles, low 1, high 3, low → no level change, no pulses, count 0. Then held stable 4+ cycles → single rise.
3. Hold: ch2 held 20 cycles after rise → btn_hold at rise+10. With macro, btn_rpt at rise+10, +13, +16, +19. Release → btn_fall and btn_hold=0 on same edge.
4. Wrap/clear: 16 presses on ch0 → cnt 0. cnt_clr[0] coincident with btn_rise[0] → cnt 0.
5. Simultaneous presses on ch0 and ch2 → both rises in same cycle, counters independent, ch1 unchanged.
6. sys_rst_n pulsed low mid-HELD with button still down → outputs 0 immediately. After release of reset, rise at +6, count 1. Without macro, btn_rpt stays 0 throughout.

Source files
------------

// File: rtl/btn_event_unit.sv
// btn_event_unit: multi-channel push-button conditioner.
// Per channel: 2-flop synchroniser, debounced level, rise/fall pulses,
// wrapping press counter, and a press/hold FSM.
// Optional auto-repeat is compiled in when BTN_AUTO_REPEAT_EN is defined;
// otherwise btn_rpt is tied to 0.
// btn_state exposes each channel's FSM state at [2*i +: 2]
// (0 = IDLE, 1 = PRESS, 2 = HELD).
module btn_event_unit #(
   parameter int BTN_NUM         = 3,
   parameter int CNT_WIDTH       = 16,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int HOLD_CYCLES     = 50000000,
   parameter int REPEAT_CYCLES   = 10000000
) (
   input  logic                           sys_clk,
   input  logic                           sys_rst_n,
   input  logic [BTN_NUM-1:0]             btn_raw,
   input  logic [BTN_NUM-1:0]             cnt_clr,
   output logic [BTN_NUM-1:0]             btn_level,
   output logic [BTN_NUM-1:0]             btn_rise,
   output logic [BTN_NUM-1:0]             btn_fall,
   output logic [BTN_NUM-1:0]             btn_hold,
   output logic [BTN_NUM-1:0]             btn_rpt,
   output logic [BTN_NUM*CNT_WIDTH-1:0]   btn_cnt,
   output logic [2*BTN_NUM-1:0]           btn_state
);

   localparam int DBW = $clog2(DEBOUNCE_CYCLES);
   localparam int HW  = $clog2(HOLD_CYCLES);
   localparam logic [DBW-1:0] DB_MAX   = DBW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0]  HOLD_MAX = HW'(HOLD_CYCLES - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_PRESS = 2'd1;
   localparam logic [1:0] ST_HELD  = 2'd2;

   // Reject parameter values the counters cannot represent.
   if (BTN_NUM < 1 || DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
      $error("btn_event_unit: illegal parameter value");
   end

   logic [BTN_NUM-1:0] sync_q1;
   logic [BTN_NUM-1:0] sync;
   logic [DBW-1:0]     db_cnt   [BTN_NUM];
   logic [HW-1:0]      hold_cnt [BTN_NUM];
   logic [1:0]         state    [BTN_NUM];
   logic [CNT_WIDTH-1:0] cnt    [BTN_NUM];
   logic [BTN_NUM-1:0] toggle;
   logic [BTN_NUM-1:0] rise_ev;
   logic [BTN_NUM-1:0] fall_ev;
   logic [BTN_NUM-1:0] held_entry;

   // Accepted level changes this cycle; a toggle is the only source of rise/fall.
   always_comb begin
      toggle     = '0;
      rise_ev    = '0;
      fall_ev    = '0;
      held_entry = '0;
      for (int i = 0; i < BTN_NUM; i++) begin
         toggle[i]     = (sync[i] != btn_level[i]) && (db_cnt[i] == DB_MAX);
         rise_ev[i]    = toggle[i] & ~btn_level[i];
         fall_ev[i]    = toggle[i] &  btn_level[i];
         held_entry[i] = (state[i] == ST_PRESS) && !fall_ev[i] && (hold_cnt[i] == HOLD_MAX);
      end
   end

   // Synchroniser, debounce qualification, level and edge pulses.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync_q1   <= '0;
         sync      <= '0;
         btn_level <= '0;
         btn_rise  <= '0;
         btn_fall  <= '0;
         for (int i = 0; i < BTN_NUM; i++) db_cnt[i] <= '0;
      end else begin
         sync_q1   <= btn_raw;
         sync      <= sync_q1;
         btn_level <= btn_level ^ toggle;
         btn_rise  <= rise_ev;
         btn_fall  <= fall_ev;
         for (int i = 0; i < BTN_NUM; i++) begin
            // Any agreeing cycle restarts qualification, so glitches never accumulate.
            if (sync[i] == btn_level[i] || toggle[i]) db_cnt[i] <= '0;
            else                                      db_cnt[i] <= db_cnt[i] + 1'b1;
         end
      end
   end

   // Press counters; clear wins over a coincident rise.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         for (int i = 0; i < BTN_NUM; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < BTN_NUM; i++) begin
            if (cnt_clr[i])      cnt[i] <= '0;
            else if (rise_ev[i]) cnt[i] <= cnt[i] + 1'b1;
         end
      end
   end

   // Press/hold FSM per channel; btn_hold follows HELD on the same edge.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         btn_hold <= '0;
         for (int i = 0; i < BTN_NUM; i++) begin
            state[i]    <= ST_IDLE;
            hold_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < BTN_NUM; i++) begin
            case (state[i])
               ST_IDLE: begin
                  if (rise_ev[i]) begin
                     state[i]    <= ST_PRESS;
                     hold_cnt[i] <= '0;
                  end
               end
               ST_PRESS: begin
                  if (fall_ev[i]) begin
                     state[i]    <= ST_IDLE;
                     hold_cnt[i] <= '0;
                  end else if (held_entry[i]) begin
                     state[i]    <= ST_HELD;
                     btn_hold[i] <= 1'b1;
                  end else begin
                     hold_cnt[i] <= hold_cnt[i] + 1'b1;
                  end
               end
               ST_HELD: begin
                  if (fall_ev[i]) begin
                     state[i]    <= ST_IDLE;
                     hold_cnt[i] <= '0;
                     btn_hold[i] <= 1'b0;
                  end
               end
               default: begin
                  state[i]    <= ST_IDLE;
                  hold_cnt[i] <= '0;
                  btn_hold[i] <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef BTN_AUTO_REPEAT_EN
   localparam int RW = $clog2(REPEAT_CYCLES);
   localparam logic [RW-1:0] RPT_MAX = RW'(REPEAT_CYCLES - 1);
   logic [RW-1:0] rpt_cnt [BTN_NUM];

   // Auto-repeat: pulse on HELD entry, then every REPEAT_CYCLES while held; a fall suppresses it.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         btn_rpt <= '0;
         for (int i = 0; i < BTN_NUM; i++) rpt_cnt[i] <= '0;
      end else begin
         btn_rpt <= '0;
         for (int i = 0; i < BTN_NUM; i++) begin
            if (held_entry[i]) begin
               btn_rpt[i] <= 1'b1;
               rpt_cnt[i] <= '0;
            end else if (state[i] == ST_HELD && !fall_ev[i]) begin
               if (rpt_cnt[i] == RPT_MAX) begin
                  btn_rpt[i] <= 1'b1;
                  rpt_cnt[i] <= '0;
               end else begin
                  rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
               end
            end else begin
               rpt_cnt[i] <= '0;
            end
         end
      end
   end
`else
   assign btn_rpt = '0;
`endif

   // Flatten per-channel counters and FSM states onto the output buses.
   always_comb begin
      btn_cnt   = '0;
      btn_state = '0;
      for (int i = 0; i < BTN_NUM; i++) begin
         btn_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt[i];
         btn_state[2*i +: 2]               = state[i];
      end
   end

endmodule
